// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle for muldiv_unit.
// master: requester side (drives start/op/a/b). slave: the unit itself.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, err, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, err, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit.
// - op 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
// - Latency: done pulses WIDTH+1 edges after the accepting edge.
// - Operands are converted to magnitudes at accept.
// - A shared 2*WIDTH accumulator runs shift-add (multiply) or
//   restoring shift-subtract (divide). Signs are reapplied in FIN.
// - Optional feature: define MULDIV_DIVIDER_EN to build the divider.
//   Without it, divide ops complete with err=1 and leave hi/lo unchanged.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_unit_if.slave bus
);

  localparam int                  CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]       CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]       CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]       CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]    ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]    ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]    ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]  ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         state_r;
  logic [CW-1:0]      cnt_r;
  logic               op_div_r;   // 1 = divide, 0 = multiply
  logic               a_neg_r;
  logic               b_neg_r;
  logic [WIDTH-1:0]   opnd_r;     // |a| for multiply, |b| for divide
  logic [2*WIDTH-1:0] acc_r;      // {upper, lower} working register
  logic               busy_r;
  logic               done_r;
  logic               err_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;

`ifdef MULDIV_DIVIDER_EN
  logic               div0_r;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
`endif

  // Two's complement negate, used for magnitude and sign correction.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Operand sign flags and magnitudes at the accepting edge; op[0]=0 is signed.
  always_comb begin
    a_neg_s = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg_s = ~bus.op[0] & bus.b[WIDTH-1];
    if (a_neg_s) begin
      mag_a_s = neg_w(bus.a);
    end else begin
      mag_a_s = bus.a;
    end
    if (b_neg_s) begin
      mag_b_s = neg_w(bus.b);
    end else begin
      mag_b_s = bus.b;
    end
  end

  // One radix-2 iteration of the selected operation.
  always_comb begin
    acc_next_s = acc_r;
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
`ifdef MULDIV_DIVIDER_EN
    shifted_s = acc_r[2*WIDTH-1:WIDTH-1];
`endif
    if (!op_div_r) begin
      // Shift-add: add multiplicand into upper half, shift right.
      acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end else begin
`ifdef MULDIV_DIVIDER_EN
      // Restoring divide: {rem, quo} shifts left, subtract when it fits.
      if (shifted_s >= {1'b0, opnd_r}) begin
        acc_next_s = {WIDTH'(shifted_s - {1'b0, opnd_r}), acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
`else
      acc_next_s = acc_r;
`endif
    end
  end

  // Sign correction of the finished accumulator.
  always_comb begin
    if (a_neg_r ^ b_neg_r) begin
      prod_s = ~acc_r + ONE_2W;
    end else begin
      prod_s = acc_r;
    end
`ifdef MULDIV_DIVIDER_EN
    if (div0_r) begin
      quo_s = ONES_W;
    end else if (a_neg_r ^ b_neg_r) begin
      quo_s = neg_w(acc_r[WIDTH-1:0]);
    end else begin
      quo_s = acc_r[WIDTH-1:0];
    end
    // Remainder follows the dividend sign; with b=0 this restores a.
    if (a_neg_r) begin
      rem_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
    end else begin
      rem_s = acc_r[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Control FSM, iteration counter, datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_ZERO;
      op_div_r <= 1'b0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      opnd_r   <= ZERO_W;
      acc_r    <= {ZERO_W, ZERO_W};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      hi_r     <= ZERO_W;
      lo_r     <= ZERO_W;
`ifdef MULDIV_DIVIDER_EN
      div0_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            op_div_r <= bus.op[1];
            a_neg_r  <= a_neg_s;
            b_neg_r  <= b_neg_s;
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b1;
            state_r  <= S_CALC;
            if (bus.op[1]) begin
              opnd_r <= mag_b_s;
              acc_r  <= {ZERO_W, mag_a_s};
            end else begin
              opnd_r <= mag_a_s;
              acc_r  <= {ZERO_W, mag_b_s};
            end
`ifdef MULDIV_DIVIDER_EN
            div0_r <= (bus.b == ZERO_W);
`endif
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= S_FIN;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIN: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= S_IDLE;
          if (!op_div_r) begin
            hi_r  <= prod_s[2*WIDTH-1:WIDTH];
            lo_r  <= prod_s[WIDTH-1:0];
            err_r <= 1'b0;
          end else begin
`ifdef MULDIV_DIVIDER_EN
            hi_r  <= rem_s;
            lo_r  <= quo_s;
            err_r <= div0_r;
`else
            err_r <= 1'b1;
`endif
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) with a result scoreboard.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  res_t         sb_q[$];
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;
  int           n_checks = 0;
  int           n_errors = 0;

  // Reference model; prior hi/lo are kept when no result is written.
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] ph, input logic [W-1:0] pl);
    res_t r;
    logic signed [2*W-1:0] sp;
    logic [2*W-1:0] up;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    r.hi = ph; r.lo = pl; r.err = 1'b0;
    sa = a; sb = b;
    case (op)
      2'b00: begin
        sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        r.hi = sp[2*W-1:W]; r.lo = sp[W-1:0];
      end
      2'b01: begin
        up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r.hi = up[2*W-1:W]; r.lo = up[W-1:0];
      end
      default: begin
`ifdef MULDIV_DIVIDER_EN
        if (b == 32'd0) begin
          r.hi = a; r.lo = 32'hFFFF_FFFF; r.err = 1'b1;
        end else if (op == 2'b11) begin
          r.lo = a / b; r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else begin
          r.lo = sa / sb; r.hi = sa % sb;
        end
`else
        r.err = 1'b1;
`endif
      end
    endcase
    return r;
  endfunction

  // Present an operation, record its expected result, return just after the accepting edge.
  task automatic drive_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    r = model(op, a, b, prev_hi, prev_lo);
    prev_hi = r.hi; prev_lo = r.lo;
    sb_q.push_back(r);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen; -1 when the bound expires.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
    n_checks++; if (bus.hi !== 32'd0) begin n_errors++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_errors++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_over_start busy=%b want=0", bus.busy); end
    prev_hi = 32'd0; prev_lo = 32'd0;
  endtask

  task automatic test_mult();
    int e; res_t exp; res_t got;
    drive_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL mult_busy got=%b want=1", bus.busy); end
    wait_done(e);
    n_checks++; if (e !== LAT) begin n_errors++; $display("FAIL mult_latency got=%0d want=%0d", e, LAT); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL mult_busy_at_done got=%b want=0", bus.busy); end
    exp = sb_q.pop_front(); got = {bus.hi, bus.lo, bus.err};
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL mult_result got=%h/%h/%b want=%h/%h/%b", got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
    bus.a = 32'd11; bus.b = 32'd13; bus.op = 2'b01;
    @(posedge clk); #1;
    n_checks++; if (bus.done !== 1'b0) begin n_errors++; $display("FAIL done_width got=%b want=0", bus.done); end
    repeat (3) @(posedge clk);
    #1; got = {bus.hi, bus.lo, bus.err};
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL result_hold got=%h/%h/%b want=%h/%h/%b", got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
  endtask

  task automatic test_back_to_back();
    int e; res_t exp; res_t got;
    drive_op(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(e);
    n_checks++; if (e !== LAT) begin n_errors++; $display("FAIL multu_latency got=%0d want=%0d", e, LAT); end
    exp = sb_q.pop_front(); got = {bus.hi, bus.lo, bus.err};
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL multu_result got=%h/%h/%b want=%h/%h/%b", got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
    drive_op(2'b11, 32'd100, 32'd7);
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept busy=%b want=1", bus.busy); end
    wait_done(e);
    n_checks++; if (e !== LAT) begin n_errors++; $display("FAIL b2b_latency got=%0d want=%0d", e, LAT); end
    exp = sb_q.pop_front(); got = {bus.hi, bus.lo, bus.err};
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL b2b_divu got=%h/%h/%b want=%h/%h/%b", got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
  endtask

  task automatic test_divide();
    logic [1:0] ops [5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [W-1:0] as [5] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [W-1:0] bs [5] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd1};
    int e; res_t exp; res_t got;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      wait_done(e);
      n_checks++; if (e !== LAT) begin n_errors++; $display("FAIL div%0d_latency got=%0d want=%0d", i, e, LAT); end
      exp = sb_q.pop_front(); got = {bus.hi, bus.lo, bus.err};
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL div%0d_result got=%h/%h/%b want=%h/%h/%b", i, got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    bit seen;
    drive_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    void'(sb_q.pop_back());
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL abort_done seen=%b want=0", seen); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    n_checks++; if (bus.hi !== 32'd0) begin n_errors++; $display("FAIL abort_hi got=%h want=0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_errors++; $display("FAIL abort_lo got=%h want=0", bus.lo); end
    prev_hi = 32'd0; prev_lo = 32'd0;
  endtask

  task automatic test_ignore();
    int e; res_t exp; res_t got;
    drive_op(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    e = -1;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd77; bus.b = 32'd3; end
      if (k == 5) begin bus.start = 1'b0; bus.op = 2'b01; bus.a = 32'hFFFF_0000; bus.b = 32'h7; end
      if (bus.done === 1'b1) begin e = k; break; end
    end
    n_checks++; if (e !== LAT) begin n_errors++; $display("FAIL ignore_latency got=%0d want=%0d", e, LAT); end
    exp = sb_q.pop_front(); got = {bus.hi, bus.lo, bus.err};
    n_checks++; if (got !== exp) begin n_errors++; $display("FAIL ignore_result got=%h/%h/%b want=%h/%h/%b", got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
    @(posedge clk); #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL ignore_no_restart busy=%b want=0", bus.busy); end
  endtask

  task automatic test_random();
    int e; res_t exp; res_t got;
    int n_ops = 1000;
    drive_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    for (int i = 0; i < n_ops; i++) begin
      wait_done(e);
      n_checks++; if (e !== LAT) begin n_errors++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, e, LAT); end
      exp = sb_q.pop_front(); got = {bus.hi, bus.lo, bus.err};
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand%0d_result got=%h/%h/%b want=%h/%h/%b", i, got.hi, got.lo, got.err, exp.hi, exp.lo, exp.err); end
      if (i < n_ops - 1) drive_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_mult();
    test_back_to_back();
    test_divide();
    test_ignore();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
